// File: rtl/vdc_ram_arbiter.sv
// VDC video RAM port arbiter: video fetch owns the port whenever it asks; CPU R31
// accesses and R30 block fill/copy run in the remaining free cycles.
module vdc_ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              upd_load,
  input  logic [ADDR_W-1:0] upd_addr_in,
  input  logic              src_load,
  input  logic [ADDR_W-1:0] src_addr_in,
  input  logic              cpu_wr_req,
  input  logic              cpu_rd_req,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              blk_start,
  input  logic              blk_copy,
  input  logic [7:0]        blk_count,
  output logic              busy,
  output logic [ADDR_W-1:0] upd_addr,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RD      = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] FILL    = 3'd4;
  localparam logic [2:0] CP_RD   = 3'd5;
  localparam logic [2:0] CP_WR   = 3'd6;

  logic [2:0]        state, state_nx;
  logic [8:0]        cnt;
  logic [DATA_W-1:0] wdata_lat;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] vid_hold;
  logic              cp_first;
  logic              free;
  logic              upd_inc, src_inc, cnt_dec;

  assign free = ~vid_req;
  assign busy = (state != IDLE);
  assign vid_data = vid_valid ? ram_rdata : vid_hold;

  always_comb begin
    state_nx = state;
    upd_inc  = 1'b0;
    src_inc  = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_wr_req)      state_nx = WR;
        else if (cpu_rd_req) state_nx = RD;
        else if (blk_start)  state_nx = blk_copy ? CP_RD : FILL;
      end
      WR: if (free) begin
        upd_inc  = 1'b1;
        state_nx = IDLE;
      end
      RD: if (free) state_nx = RD_WAIT;
      RD_WAIT: begin
        upd_inc  = 1'b1;
        state_nx = IDLE;
      end
      FILL: if (free) begin
        upd_inc = 1'b1;
        cnt_dec = 1'b1;
        if (cnt == 9'd1) state_nx = IDLE;
      end
      CP_RD: if (free) state_nx = CP_WR;
      CP_WR: if (free) begin
        upd_inc  = 1'b1;
        src_inc  = 1'b1;
        cnt_dec  = 1'b1;
        state_nx = (cnt == 9'd1) ? IDLE : CP_RD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Port mux: video wins outright, otherwise the FSM state picks the access.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (vid_req) begin
      ram_addr = vid_addr;
    end else begin
      case (state)
        WR, FILL: begin
          ram_addr  = upd_addr;
          ram_we    = 1'b1;
          ram_wdata = wdata_lat;
        end
        RD: ram_addr = upd_addr;
        CP_RD: ram_addr = src_addr;
        CP_WR: begin
          ram_addr  = upd_addr;
          ram_we    = 1'b1;
          ram_wdata = cp_first ? ram_rdata : hold;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cp_first  <= 1'b0;
      vid_valid <= 1'b0;
      vid_hold  <= '0;
      cpu_rdata <= '0;
      upd_addr  <= '0;
      src_addr  <= '0;
    end else begin
      state     <= state_nx;
      vid_valid <= vid_req;
      if (vid_valid) vid_hold <= ram_rdata;
      if (state == RD_WAIT) cpu_rdata <= ram_rdata;
      if (state == IDLE && !cpu_wr_req && !cpu_rd_req && blk_start)
        cnt <= (blk_count == 8'd0) ? 9'd256 : {1'b0, blk_count};
      else if (cnt_dec)
        cnt <= cnt - 9'd1;
      // The fetched source byte is only on ram_rdata during the first CP_WR cycle.
      if (state == CP_RD && free) cp_first <= 1'b1;
      else if (state == CP_WR)    cp_first <= 1'b0;
      if (upd_load)     upd_addr <= upd_addr_in;
      else if (upd_inc) upd_addr <= upd_addr + 1'b1;
      if (src_load)     src_addr <= src_addr_in;
      else if (src_inc) src_addr <= src_addr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE) wdata_lat <= cpu_wdata;
    if (state == CP_WR && cp_first) hold <= ram_rdata;
  end

endmodule
